// File: rtl/modn_updown_counter_multi.sv
// modn_updown_counter_multi: chained radix-MODULUS up/down counter with clamped load, wrap/saturate and event pulses
module modn_updown_counter_multi #(
   parameter int MODULUS = 10,
   parameter int DIGITS = 2,
   parameter bit WRAP = 1'b1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                en,
   input  logic                up_down,
   input  logic                load,
   input  logic [4*DIGITS-1:0] load_val,
   output logic [4*DIGITS-1:0] out,
   output logic                tc,
   output logic                limit,
   output logic                load_err
);
   localparam logic [3:0] MAX = 4'(MODULUS - 1);
   localparam logic [4:0] MOD = 5'(MODULUS);
   logic [4*DIGITS-1:0] r_out, w_next, w_clamp;
   logic [DIGITS-1:0] w_adv, w_step, w_bad;
   logic r_limit, r_load_err, w_bound;
   if (MODULUS < 2 || MODULUS > 16 || DIGITS < 1 || DIGITS > 8) begin : g_bad_param
      $error("modn_updown_counter_multi: MODULUS must be 2..16 and DIGITS 1..8");
   end
   for (genvar i = 0; i < DIGITS; i++) begin : g_dig
      logic [3:0] w_d, w_l;
      assign w_d = r_out[4*i+:4];
      assign w_l = load_val[4*i+:4];
      assign w_adv[i] = up_down ? (w_d == MAX) : (w_d == 4'd0);
      if (i == 0) begin : g_lsd
         assign w_step[i] = 1'b1;
      end else begin : g_upper
         assign w_step[i] = w_step[i-1] & w_adv[i-1];
      end
      assign w_bad[i] = {1'b0, w_l} >= MOD;
      assign w_clamp[4*i+:4] = w_bad[i] ? MAX : w_l;
      assign w_next[4*i+:4] = !w_step[i] ? w_d :
                              up_down ? (w_adv[i] ? 4'd0 : w_d + 4'd1) :
                              (w_adv[i] ? MAX : w_d - 4'd1);
   end
   assign w_bound = &w_adv;
   assign tc = en & w_bound;
   always_ff @(posedge clk) begin
      if (rst) begin
         r_out <= '0;
         r_limit <= 1'b0;
         r_load_err <= 1'b0;
      end else if (load) begin
         r_out <= w_clamp;
         r_limit <= 1'b0;
         r_load_err <= |w_bad;
      end else begin
         r_out <= (en && !(w_bound && !WRAP)) ? w_next : r_out;
         r_limit <= en & w_bound;
         r_load_err <= 1'b0;
      end
   end
   assign out = r_out;
   assign limit = r_limit;
   assign load_err = r_load_err;
endmodule

// File: tb/tb_modn_updown_counter_multi.sv
// tb_modn_updown_counter_multi: directed checks of a wrapping and a saturating 2-digit decimal counter
module tb_modn_updown_counter_multi;
   logic clk = 1'b0;
   logic rst, en, up_down, load;
   logic [7:0] load_val;
   logic [7:0] out_w, out_s;
   logic tc_w, tc_s, limit_w, limit_s, err_w, err_s;
   int total = 0;
   int bad = 0;
   always #5 clk = ~clk;
   modn_updown_counter_multi #(.MODULUS(10), .DIGITS(2), .WRAP(1'b1)) u_wrap (
      .clk(clk), .rst(rst), .en(en), .up_down(up_down), .load(load), .load_val(load_val),
      .out(out_w), .tc(tc_w), .limit(limit_w), .load_err(err_w)
   );
   modn_updown_counter_multi #(.MODULUS(10), .DIGITS(2), .WRAP(1'b0)) u_sat (
      .clk(clk), .rst(rst), .en(en), .up_down(up_down), .load(load), .load_val(load_val),
      .out(out_s), .tc(tc_s), .limit(limit_s), .load_err(err_s)
   );
   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   initial begin
      logic [7:0] e;
      rst = 1'b1; en = 1'b0; up_down = 1'b1; load = 1'b0; load_val = 8'h00;
      step();
      step();
      chk("rst_out", out_w, 8'h00);
      chk("rst_limit", {7'd0, limit_w}, 8'h00);
      chk("rst_err", {7'd0, err_w}, 8'h00);
      chk("rst_tc_idle", {7'd0, tc_w}, 8'h00);
      en = 1'b1; up_down = 1'b0;
      #1;
      chk("rst_tc_down", {7'd0, tc_w}, 8'h01);
      up_down = 1'b1; rst = 1'b0;
      #1;
      chk("tc_up_at0", {7'd0, tc_w}, 8'h00);
      for (int k = 1; k <= 100; k++) begin
         step();
         e = {4'((k % 100) / 10), 4'(k % 10)};
         chk($sformatf("up_out_%0d", k), out_w, e);
         chk($sformatf("up_limit_%0d", k), {7'd0, limit_w}, {7'd0, k == 100});
         chk($sformatf("up_tc_%0d", k), {7'd0, tc_w}, {7'd0, k == 99});
      end
      up_down = 1'b0;
      #1;
      chk("down_tc_at0", {7'd0, tc_w}, 8'h01);
      step(); chk("down_out1", out_w, 8'h99); chk("down_limit1", {7'd0, limit_w}, 8'h01);
      step(); chk("down_out2", out_w, 8'h98); chk("down_limit2", {7'd0, limit_w}, 8'h00);
      step(); chk("down_out3", out_w, 8'h97); chk("down_limit3", {7'd0, limit_w}, 8'h00);
      en = 1'b0; load = 1'b1; load_val = 8'h98;
      step(); chk("sat_load", out_s, 8'h98);
      load = 1'b0; en = 1'b1; up_down = 1'b1;
      step(); chk("sat_out1", out_s, 8'h99); chk("sat_limit1", {7'd0, limit_s}, 8'h00);
      chk("sat_tc", {7'd0, tc_s}, 8'h01);
      step(); chk("sat_out2", out_s, 8'h99); chk("sat_limit2", {7'd0, limit_s}, 8'h01);
      step(); chk("sat_out3", out_s, 8'h99); chk("sat_limit3", {7'd0, limit_s}, 8'h01);
      step(); chk("sat_out4", out_s, 8'h99); chk("sat_limit4", {7'd0, limit_s}, 8'h01);
      load = 1'b1; load_val = 8'h3C;
      step(); chk("clamp_out", out_w, 8'h39); chk("clamp_err", {7'd0, err_w}, 8'h01);
      chk("clamp_limit", {7'd0, limit_w}, 8'h00);
      load_val = 8'h47;
      step(); chk("load_out", out_w, 8'h47); chk("load_err_clr", {7'd0, err_w}, 8'h00);
      load_val = 8'hFF;
      step(); chk("clamp_both", out_w, 8'h99); chk("clamp_both_err", {7'd0, err_w}, 8'h01);
      load = 1'b0; en = 1'b0;
      step(); chk("hold_out", out_w, 8'h99); chk("hold_err", {7'd0, err_w}, 8'h00);
      load = 1'b1; load_val = 8'h45;
      step(); chk("dir_load", out_w, 8'h45);
      load = 1'b0; en = 1'b1; up_down = 1'b1;
      step(); chk("dir_u1", out_w, 8'h46);
      step(); chk("dir_u2", out_w, 8'h47);
      step(); chk("dir_u3", out_w, 8'h48);
      up_down = 1'b0;
      step(); chk("dir_d1", out_w, 8'h47);
      step(); chk("dir_d2", out_w, 8'h46);
      step(); chk("dir_d3", out_w, 8'h45);
      step(); chk("dir_d4", out_w, 8'h44);
      step(); chk("dir_d5", out_w, 8'h43);
      en = 1'b0;
      step(); chk("dir_h1", out_w, 8'h43);
      step(); chk("dir_h2", out_w, 8'h43);
      load = 1'b1; load_val = 8'h40;
      step();
      load = 1'b0; en = 1'b1;
      step(); chk("borrow", out_w, 8'h39);
      load = 1'b1; en = 1'b0; load_val = 8'h57;
      step(); chk("mid_load", out_w, 8'h57);
      load_val = 8'h9A; en = 1'b1; rst = 1'b1;
      step(); chk("mid_rst_out", out_w, 8'h00);
      chk("mid_rst_limit", {7'd0, limit_w}, 8'h00); chk("mid_rst_err", {7'd0, err_w}, 8'h00);
      rst = 1'b0; load = 1'b0; up_down = 1'b1;
      step(); chk("resume1", out_w, 8'h01);
      step(); chk("resume2", out_w, 8'h02);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/modn_updown_counter_multi.md
# modn_updown_counter_multi

Parametrised multi-digit modulo-N up/down counter, the successor to the single-digit mod-10 up/down counter. It chains DIGITS radix-MODULUS digits into one synchronous counter. It adds count enable, parallel load with range checking, selectable wrap or saturate mode, a combinational terminal-count output for cascading, and a registered limit-event pulse. It serves event counters, BCD displays and timers that need a wider count than one decade.

## Interface
- MODULUS, 10, radix of every digit; legal range 2..16.
- DIGITS, 2, number of cascaded digits; legal range 1..8.
- WRAP, 1, boundary mode: 1 = wrap around, 0 = saturate and hold.
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  synchronous, active-high reset, sampled on clk rising edge.
- en  input  1  count enable; one step per clock while high.
- up_down  input  1  direction: 1 = count up, 0 = count down.
- load  input  1  parallel load strobe; priority over en.
- load_val  input  4*DIGITS  load value; digit i in bits [4i+3:4i].
- out  output  4*DIGITS  registered count; digit i in bits [4i+3:4i], digit 0 least significant.
- tc  output  1  combinational terminal count for cascading.
- limit  output  1  registered one-cycle pulse marking a boundary event.
- load_err  output  1  registered one-cycle pulse marking an out-of-range load digit.

## Operation
- **Priority per edge:** rst, then load, then en, then hold.
- **Reset:** out = 0, limit = 0, load_err = 0. tc then follows its equation, so it is high when en=1 and up_down=0.
- **Load:**
  - Each load_val digit ≥ MODULUS is clamped to MODULUS-1 and the others load unchanged.
  - load_err = 1 on the next cycle if any digit was clamped.
  - limit = 0 on a load cycle.
  - en is ignored on a load cycle.
- **Count up (en=1, up_down=1):**
  - Digit i increments when every lower digit equals MODULUS-1; digit 0 always increments.
  - A digit at MODULUS-1 that increments becomes 0.
- **Count down (en=1, up_down=0):**
  - Digit i decrements when every lower digit equals 0.
  - A digit at 0 that decrements becomes MODULUS-1.
- **Boundary:** the boundary is all digits = MODULUS-1 when counting up, or all digits = 0 when counting down.
  - WRAP=1: out goes to all-0 (up) or all-(MODULUS-1) (down).
  - WRAP=0: out holds.
  - In both modes limit = 1 on the next cycle.
- **tc** = en & (up_down ? all digits == MODULUS-1 : all digits == 0). It has no register stage, so the next stage's en can be driven by this stage's tc.
- **Direction change:** up_down is sampled every edge. Reversing direction mid-count needs no settling cycle and carries no penalty.
- **Holding:** en=0 with load=0 holds out. limit and load_err are 0.
- **Digit width:** always 4 bits. When MODULUS < 16 the codes MODULUS..15 are never produced.
- **Parameter checks:** illegal parameter values are rejected at elaboration by a generate-time check.

## Timing
- out, limit and load_err update only on the clk rising edge. Latency from a sampled input to out is 1 cycle.
- tc responds combinationally to en, up_down and the current out within the same cycle.
- limit and load_err are single-cycle pulses. They repeat every cycle while the condition repeats, for example en held at a saturated boundary.
- **rst asserted mid-count:** out = 0 on that edge regardless of load or en. Pending limit and load_err are cleared.
- **rst and load together:** rst wins and load_val is discarded.
- **First edge after reset release:** counting resumes from 0 on the first edge with rst=0. No idle cycle is inserted.

## Test plan
- **Reset and first count up:** MODULUS=10, DIGITS=2, WRAP=1. Hold rst 2 cycles, then en=1, up_down=1 for 100 cycles. out reads 00, 01..09, 10..99, then 00. limit pulses exactly once, one cycle after 99→00. tc is high only while out=99.
- **Count down from the bottom:** from 00 with en=1, up_down=0, give 3 cycles. out reads 99, 98, 97. limit pulses on the cycle after 00→99.
- **Saturate mode:** WRAP=0, load 98, then en=1, up_down=1 for 4 cycles. out reads 99, 99, 99, 99. limit is high on the 2nd, 3rd and 4th cycles.
- **Load clamping and priority:** load_val=0x3C with load=1 and en=1. The result is out=0x39 and load_err=1 for one cycle. load_val=0x47 with load=1 gives out=0x47 and load_err=0.
- **Mid-count direction and enable changes:** from 45, run up 3 cycles, then down 5 cycles, then en=0 for 2 cycles. out reads 46, 47, 48, 47, 46, 45, 44, 43, 43, 43.
- **Reset mid-operation:** at out=57 with en=1 and load=1, assert rst for 1 cycle. out=00, limit=0 and load_err=0 on the next cycle. Counting resumes 01, 02 after release.
